dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single data-memory port between two requesters: port 0, the CPU load/store path, and port 1, the program loader/debug port. Each requester uses a req/gnt/rvalid handshake. The block registers the winning command, drives one memory access, waits a fixed memory latency, and returns the response to the owner. It sits between the CPU memory stage and `data_mem`, and replaces the CPU's direct connection to `data_mem`.

## Interface
- `MEM_LATENCY`, 1: cycles from `mem_en` to valid `mem_rdata`; minimum 1.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req` in 2: per-port request; bit 0 is CPU, bit 1 is loader.
- `we` in 2: per-port write enable.
- `addr0`, `addr1` in ADDR_W: per-port address.
- `wdata0`, `wdata1` in DATA_W: per-port write data.
- `bs0`, `bs1` in 2: per-port byte select (00 byte, 01 half, 10 word).
- `se` in 2: per-port sign-extend on load.
- `gnt` out 2: one-hot, one-cycle pulse when the port's command is issued.
- `rvalid` out 2: one-hot, one-cycle completion pulse to the owner.
- `rdata` out DATA_W: load data, valid only with `rvalid`.
- `busy` out 1: high in any state other than IDLE.
- `mem_en`, `mem_we`, `mem_se` out 1: memory command.
- `mem_bs` out 2: memory byte select.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **Arbitration** happens in IDLE and in RESP. It samples `req` and picks a winner. At the clock edge it captures the winner's `we`, `addr`, `wdata`, `bs` and `se` into the command register and records the owner.
  - If no request is pending: IDLE stays IDLE, and RESP goes to IDLE.
- **ISSUE** (one cycle):
  - `mem_en`=1 and `gnt[owner]`=1.
  - Memory outputs are driven from the command register.
  - The wait counter loads MEM_LATENCY-1.
  - Next state is WAIT.
- **WAIT**:
  - `mem_en`=0.
  - The counter decrements each cycle.
  - When the counter is 0 and the command is a read, `mem_rdata` is captured into `rdata`.
  - Next state is RESP.
- **RESP** (one cycle):
  - `rvalid[owner]`=1.
  - `rdata` holds the captured data for reads and 0 for writes.
  - Arbitration for the next transaction happens in this same cycle.
- **Requester rule:** hold `req` and the command stable until `gnt`. Drop `req` in the cycle after `gnt` unless issuing another transaction. A `req` dropped before `gnt` is ignored without side effect.
- **Contention policy:** round-robin by default. A `last` pointer records the previously served port. When both ports request, the port not equal to `last` wins. `last` updates at ISSUE.
- **Outputs:**
  - `mem_*` outputs are 0 outside ISSUE, except `mem_addr`, `mem_wdata`, `mem_bs`, `mem_se`, which hold the command register.
  - `gnt` and `rvalid` are never asserted together for the same port.

## Timing
- Reset state: IDLE. All outputs 0. Command register 0. Counter 0. `last`=1, so the CPU wins the first contention.
- Latency: `req` sampled at the edge ending cycle 0 gives `gnt` in cycle 1 and `rvalid` in cycle MEM_LATENCY+2.
- Throughput: one transaction per MEM_LATENCY+2 cycles under continuous requests.
- Reset asserted mid-transaction: abort immediately with no `rvalid`. An issued write may already have completed in memory.
- Both ports request while another transaction is in flight: they wait. Only one is served per RESP arbitration.
- MEM_LATENCY=1: WAIT lasts exactly one cycle.

## Configuration
- `DMEM_ARB_CPU_PRIO_EN` defined: fixed priority. Port 0 always wins contention and `last` is unused. The loader is served only when the CPU is not requesting at an arbitration point.
- `DMEM_ARB_CPU_PRIO_EN` undefined: round-robin as described in Operation.

## Structure
- `dmem_arb_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - port index constants `PORT_CPU`=0 and `PORT_LDR`=1;
  - byte-select constants `BS_BYTE`, `BS_HALF`, `BS_WORD`.
- Sub-module `dmem_arb_pick`: combinational two-way picker taking `req`, `last` and the priority mode, producing a one-hot winner.
- Command register, counter and FSM live in `dmem_arbiter`.

## Test plan
- CPU read alone, MEM_LATENCY=1: `req`=01, `addr0`=0x10, memory returns 0xDEADBEEF. Expect `gnt`=01 in cycle 1, `mem_en` in cycle 1, and `rvalid`=01 with `rdata`=0xDEADBEEF in cycle 3.
- Loader write: `req`=10, `we`=10, `addr1`=0x20, `wdata1`=0x1234, `bs1`=10. Expect `mem_we`=1, `mem_addr`=0x20, `mem_wdata`=0x1234 in the ISSUE cycle, then `rvalid`=10 with `rdata`=0.
- Contention, round-robin: `req`=11 held continuously after reset. Expect grant order CPU, loader, CPU, loader, each spaced MEM_LATENCY+2 cycles.
- Contention with `DMEM_ARB_CPU_PRIO_EN` and `req`=11 held: expect the CPU granted every transaction and the loader never granted. Dropping `req[0]` gives the loader the grant at the next arbitration.
- MEM_LATENCY=3, CPU read: expect WAIT for 3 cycles, `rvalid` in cycle 5, and `rdata` taken from `mem_rdata` in the last WAIT cycle.
- Reset in WAIT: assert `rst` mid-transaction. Expect all outputs 0 immediately, no `rvalid`, and `busy`=0. A new request after release is served normally.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    localparam logic [1:0] BS_BYTE = 2'b00;
    localparam logic [1:0] BS_HALF = 2'b01;
    localparam logic [1:0] BS_WORD = 2'b10;

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way request picker: one-hot winner from req, using either
// round-robin against the last served port or fixed CPU priority.
module dmem_arb_pick #(
    parameter bit CPU_PRIO = 1'b0
) (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);
    import dmem_arb_pkg::*;

    // On contention the port other than 'last' wins, unless CPU priority is fixed.
    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = (CPU_PRIO || last == PORT_LDR) ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU (port 0) and the
// program loader (port 1). One access in flight at a time.
// Build option: DMEM_ARB_CPU_PRIO_EN selects fixed CPU priority instead of
// round-robin.
module dmem_arbiter #(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [1:0]        bs0,
    input  logic [1:0]        bs1,
    input  logic [1:0]        se,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_se,
    output logic [1:0]        mem_bs,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    import dmem_arb_pkg::*;

`ifdef DMEM_ARB_CPU_PRIO_EN
    localparam bit CPU_PRIO = 1'b1;
`else
    localparam bit CPU_PRIO = 1'b0;
`endif

    localparam int               CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic                cmd_we_q, cmd_we_d;
    logic                cmd_se_q, cmd_se_d;
    logic [1:0]          cmd_bs_q, cmd_bs_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          win;

    dmem_arb_pick #(.CPU_PRIO(CPU_PRIO)) u_pick (
        .req  (req),
        .last (last_q),
        .win  (win)
    );

    // Next-state: arbitrate/capture in IDLE and RESP, time the access in WAIT.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cmd_we_d    = cmd_we_q;
        cmd_se_d    = cmd_se_q;
        cmd_bs_d    = cmd_bs_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE, RESP: begin
                if (|req) begin
                    state_d     = ISSUE;
                    owner_d     = win[1];
                    cmd_we_d    = win[1] ? we[1] : we[0];
                    cmd_se_d    = win[1] ? se[1] : se[0];
                    cmd_bs_d    = win[1] ? bs1 : bs0;
                    cmd_addr_d  = win[1] ? addr1 : addr0;
                    cmd_wdata_d = win[1] ? wdata1 : wdata0;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_LOAD;
                last_d  = owner_q;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    // writes complete with zero data so rdata never leaks a stale load
                    rdata_d = cmd_we_q ? '0 : mem_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and command registers; last starts at the loader so the CPU wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= PORT_CPU;
            last_q      <= PORT_LDR;
            cmd_we_q    <= 1'b0;
            cmd_se_q    <= 1'b0;
            cmd_bs_q    <= '0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cmd_we_q    <= cmd_we_d;
            cmd_se_q    <= cmd_se_d;
            cmd_bs_q    <= cmd_bs_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
        end
    end

    // Handshake pulses and memory strobes decoded from the current state.
    always_comb begin
        gnt    = 2'b00;
        rvalid = 2'b00;
        mem_en = 1'b0;
        mem_we = 1'b0;
        rdata  = '0;
        busy   = (state_q != IDLE);
        if (state_q == ISSUE) begin
            mem_en       = 1'b1;
            mem_we       = cmd_we_q;
            gnt[owner_q] = 1'b1;
        end
        if (state_q == RESP) begin
            rvalid[owner_q] = 1'b1;
            rdata           = rdata_q;
        end
    end

    assign mem_se    = cmd_se_q;
    assign mem_bs    = cmd_bs_q;
    assign mem_addr  = cmd_addr_q;
    assign mem_wdata = cmd_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run against a transaction-timing reference model. Instance u1 uses
// MEM_LATENCY=1, u3 uses MEM_LATENCY=3; both see the same requester inputs.
module tb_dmem_arbiter;

    localparam int LAT1 = 1;
    localparam int LAT3 = 3;
`ifdef DMEM_ARB_CPU_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0, we = '0, bs0 = '0, bs1 = '0, se = '0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;

    logic [1:0]  gnt1, rvalid1, mem_bs1, gnt3, rvalid3, mem_bs3;
    logic [31:0] rdata1, mem_wdata1, mem_rdata1, mem_addr1;
    logic [31:0] rdata3, mem_wdata3, mem_rdata3, mem_addr3;
    logic        busy1, mem_en1, mem_we1, mem_se1;
    logic        busy3, mem_en3, mem_we3, mem_se3;
    logic [105:0] all1, all3;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter #(.MEM_LATENCY(LAT1), .ADDR_W(32), .DATA_W(32)) u1 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .bs0(bs0), .bs1(bs1), .se(se),
        .gnt(gnt1), .rvalid(rvalid1), .rdata(rdata1), .busy(busy1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_se(mem_se1), .mem_bs(mem_bs1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    dmem_arbiter #(.MEM_LATENCY(LAT3), .ADDR_W(32), .DATA_W(32)) u3 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .bs0(bs0), .bs1(bs1), .se(se),
        .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .busy(busy3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_se(mem_se3), .mem_bs(mem_bs3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
    );

    assign all1 = {gnt1, rvalid1, rdata1, busy1, mem_en1, mem_we1, mem_se1, mem_bs1, mem_addr1, mem_wdata1};
    assign all3 = {gnt3, rvalid3, rdata3, busy3, mem_en3, mem_we3, mem_se3, mem_bs3, mem_addr3, mem_wdata3};

    // Memory content as a pure function of address.
    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Latency-accurate memory models: data valid only in the cycle MEM_LATENCY after mem_en.
    int left1, left3;
    logic [31:0] ad1, ad3;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            left1 <= 0; ad1 <= '0;
        end else if (mem_en1) begin
            left1 <= LAT1; ad1 <= mem_addr1;
        end else if (left1 > 0) begin
            left1 <= left1 - 1;
        end
    end
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            left3 <= 0; ad3 <= '0;
        end else if (mem_en3) begin
            left3 <= LAT3; ad3 <= mem_addr3;
        end else if (left3 > 0) begin
            left3 <= left3 - 1;
        end
    end
    assign mem_rdata1 = (left1 == 1) ? rd_fn(ad1) : (32'hBAD00000 | {16'h0, cyc[15:0]});
    assign mem_rdata3 = (left3 == 1) ? rd_fn(ad3) : (32'hBAD10000 | {16'h0, cyc[15:0]});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0: DUTs idle, inputs set now are sampled at the next edge.
    task automatic do_reset();
        rst = 1'b1;
        req = '0; we = '0; se = '0; bs0 = '0; bs1 = '0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0; we = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (all1 !== 106'd0) begin bad++; $display("FAIL reset_u1: got %h want 0", all1); end
        total++;
        if (all3 !== 106'd0) begin bad++; $display("FAIL reset_u3: got %h want 0", all3); end
        rst = 1'b0;
        tick();
        total++;
        if (all1 !== 106'd0) begin bad++; $display("FAIL idle_after_reset: got %h want 0", all1); end
    endtask

    task automatic test_cpu_read();
        do_reset();
        req = 2'b01; we = 2'b00; addr0 = 32'h10; bs0 = 2'b10;
        tick();
        total++;
        if ({gnt1, mem_en1, rvalid1} !== {2'b01, 1'b1, 2'b00}) begin
            bad++; $display("FAIL cpu_read_issue: got gnt=%b en=%b rv=%b want 01 1 00", gnt1, mem_en1, rvalid1);
        end
        total++;
        if (mem_addr1 !== 32'h10) begin bad++; $display("FAIL cpu_read_addr: got %h want 10", mem_addr1); end
        req = 2'b00;
        tick();
        total++;
        if ({busy1, mem_en1, rvalid1, gnt1} !== {1'b1, 1'b0, 2'b00, 2'b00}) begin
            bad++; $display("FAIL cpu_read_wait: got busy=%b en=%b rv=%b gnt=%b", busy1, mem_en1, rvalid1, gnt1);
        end
        tick();
        total++;
        if (rvalid1 !== 2'b01) begin bad++; $display("FAIL cpu_read_rvalid: got %b want 01", rvalid1); end
        total++;
        if (rdata1 !== 32'hDEADBEEF) begin bad++; $display("FAIL cpu_read_rdata: got %h want deadbeef", rdata1); end
        tick();
        total++;
        if ({busy1, rvalid1} !== 3'b000) begin bad++; $display("FAIL cpu_read_done: got busy=%b rv=%b", busy1, rvalid1); end
    endtask

    task automatic test_ldr_write();
        do_reset();
        req = 2'b10; we = 2'b10; addr1 = 32'h20; wdata1 = 32'h1234; bs1 = 2'b10;
        tick();
        total++;
        if ({gnt1, mem_en1, mem_we1, mem_bs1} !== {2'b10, 1'b1, 1'b1, 2'b10}) begin
            bad++; $display("FAIL ldr_write_issue: got gnt=%b en=%b we=%b bs=%b", gnt1, mem_en1, mem_we1, mem_bs1);
        end
        total++;
        if ({mem_addr1, mem_wdata1} !== {32'h20, 32'h1234}) begin
            bad++; $display("FAIL ldr_write_cmd: got addr=%h wdata=%h want 20 1234", mem_addr1, mem_wdata1);
        end
        req = 2'b00; we = 2'b00;
        tick();
        total++;
        if ({mem_en1, mem_we1} !== 2'b00) begin bad++; $display("FAIL ldr_write_wait: got en=%b we=%b", mem_en1, mem_we1); end
        tick();
        total++;
        if ({rvalid1, rdata1} !== {2'b10, 32'h0}) begin
            bad++; $display("FAIL ldr_write_resp: got rv=%b rdata=%h want 10 0", rvalid1, rdata1);
        end
    endtask

    task automatic test_contention();
        int per;
        logic [1:0] exp;
        do_reset();
        per = LAT1 + 2;
        req = 2'b11; we = 2'b00; addr0 = 32'h100; addr1 = 32'h200;
        for (int k = 1; k <= 4 * per; k++) begin
            tick();
            exp = 2'b00;
            if ((k - 1) % per == 0) exp = (PRIO || (((k - 1) / per) % 2 == 0)) ? 2'b01 : 2'b10;
            total++;
            if (gnt1 !== exp) begin bad++; $display("FAIL contention_gnt c%0d: got %b want %b", k, gnt1, exp); end
        end
        // CPU stops requesting at the RESP arbitration point; the loader must win next.
        req = 2'b10;
        tick();
        total++;
        if (gnt1 !== 2'b10) begin bad++; $display("FAIL contention_ldr_after_drop: got %b want 10", gnt1); end
        req = 2'b00;
        repeat (4) tick();
    endtask

    task automatic test_latency3();
        logic [1:0] eg, er;
        do_reset();
        req = 2'b01; we = 2'b00; addr0 = 32'h44;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) req = 2'b00;
            eg = (k == 1) ? 2'b01 : 2'b00;
            er = (k == LAT3 + 2) ? 2'b01 : 2'b00;
            total++;
            if ({gnt3, rvalid3, mem_en3, busy3} !== {eg, er, (k == 1), (k <= LAT3 + 2)}) begin
                bad++;
                $display("FAIL lat3 c%0d: got gnt=%b rv=%b en=%b busy=%b want %b %b %b %b",
                         k, gnt3, rvalid3, mem_en3, busy3, eg, er, (k == 1), (k <= LAT3 + 2));
            end
            if (k == LAT3 + 2) begin
                total++;
                if (rdata3 !== rd_fn(32'h44)) begin bad++; $display("FAIL lat3_rdata: got %h want %h", rdata3, rd_fn(32'h44)); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 2'b01; we = 2'b00; addr0 = 32'h30;
        tick();
        req = 2'b00;
        tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (all1 !== 106'd0) begin bad++; $display("FAIL midreset_u1: got %h want 0", all1); end
        total++;
        if (all3 !== 106'd0) begin bad++; $display("FAIL midreset_u3: got %h want 0", all3); end
        tick();
        total++;
        if ({rvalid1, busy1} !== 3'b000) begin bad++; $display("FAIL midreset_no_rvalid: got rv=%b busy=%b", rvalid1, busy1); end
        rst = 1'b0;
        tick();
        total++;
        if ({rvalid1, busy1, gnt1} !== 5'b0) begin bad++; $display("FAIL midreset_idle: got rv=%b busy=%b gnt=%b", rvalid1, busy1, gnt1); end
        req = 2'b01; addr0 = 32'h10;
        tick();
        req = 2'b00;
        total++;
        if (gnt1 !== 2'b01) begin bad++; $display("FAIL midreset_new_gnt: got %b want 01", gnt1); end
        repeat (2) tick();
        total++;
        if ({rvalid1, rdata1} !== {2'b01, 32'hDEADBEEF}) begin
            bad++; $display("FAIL midreset_new_resp: got rv=%b rdata=%h", rvalid1, rdata1);
        end
    endtask

    // Randomized requesters; the model schedules each transaction by arithmetic:
    // a request sampled at arbitration cycle c is granted at c+1 and answered at c+LAT+2.
    task automatic new_cmd(input int p);
        req[p] = 1'b1;
        we[p]  = 1'($urandom_range(0, 1));
        se[p]  = 1'($urandom_range(0, 1));
        if (p == 0) begin
            addr0 = $urandom; wdata0 = $urandom; bs0 = 2'($urandom_range(0, 2));
        end else begin
            addr1 = $urandom; wdata1 = $urandom; bs1 = 2'($urandom_range(0, 2));
        end
    endtask

    task automatic test_random(input int ncyc);
        int g_cyc, r_cyc, g_port, w;
        bit inflight, m_last, granted;
        logic ewe, ese;
        logic [1:0] ebs, eg, er;
        logic [31:0] eaddr, ewd;
        do_reset();
        inflight = 1'b0; m_last = 1'b1; g_cyc = -10; r_cyc = -1; g_port = 0;
        ewe = 1'b0; ese = 1'b0; ebs = '0; eaddr = '0; ewd = '0;
        for (int k = 0; k < ncyc; k++) begin
            eg = 2'b00; er = 2'b00;
            if (inflight && k == g_cyc) eg[g_port] = 1'b1;
            if (inflight && k == r_cyc) er[g_port] = 1'b1;
            total++;
            if ({gnt1, rvalid1, busy1, mem_en1, mem_we1} !==
                {eg, er, (inflight && k >= g_cyc && k <= r_cyc), (inflight && k == g_cyc), (inflight && k == g_cyc && ewe)}) begin
                bad++;
                $display("FAIL rand_ctl c%0d: got gnt=%b rv=%b busy=%b en=%b we=%b want gnt=%b rv=%b",
                         k, gnt1, rvalid1, busy1, mem_en1, mem_we1, eg, er);
            end
            if (inflight && k >= g_cyc) begin
                total++;
                if ({mem_addr1, mem_wdata1, mem_bs1, mem_se1} !== {eaddr, ewd, ebs, ese}) begin
                    bad++;
                    $display("FAIL rand_cmd c%0d: got %h %h %b %b want %h %h %b %b",
                             k, mem_addr1, mem_wdata1, mem_bs1, mem_se1, eaddr, ewd, ebs, ese);
                end
            end
            if (inflight && k == r_cyc) begin
                total++;
                if (rdata1 !== (ewe ? 32'h0 : rd_fn(eaddr))) begin
                    bad++; $display("FAIL rand_rdata c%0d: got %h want %h", k, rdata1, (ewe ? 32'h0 : rd_fn(eaddr)));
                end
            end
            // requesters: hold until granted, then drop or start another; rare withdrawals
            for (int p = 0; p < 2; p++) begin
                granted = inflight && k == g_cyc && g_port == p;
                if (granted) req[p] = 1'b0;
                if (!req[p]) begin
                    if ($urandom_range(0, 2) == 0) new_cmd(p);
                end else if (!granted && $urandom_range(0, 19) == 0) begin
                    req[p] = 1'b0;
                end
            end
            // arbitration point: idle, or the response cycle of the current transaction
            if (!inflight || k >= r_cyc) begin
                if (req != 2'b00) begin
                    if (req == 2'b11) w = (PRIO || m_last) ? 0 : 1;
                    else              w = req[1] ? 1 : 0;
                    g_port = w; m_last = w[0]; inflight = 1'b1;
                    g_cyc = k + 1; r_cyc = k + LAT1 + 2;
                    ewe = we[w]; ese = se[w];
                    ebs   = (w == 1) ? bs1 : bs0;
                    eaddr = (w == 1) ? addr1 : addr0;
                    ewd   = (w == 1) ? wdata1 : wdata0;
                end else begin
                    inflight = 1'b0;
                end
            end
            tick();
        end
        req = 2'b00;
        repeat (6) tick();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_ldr_write();
        test_contention();
        test_latency3();
        test_reset_mid();
        test_random(600);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
